// File: rtl/eth_drr_arbiter.sv
// eth_drr_arbiter: deficit-round-robin frame scheduler driving a frame mux grant.
// Optional feature macro ETH_DRR_ARBITER_STRICT_PRIO_EN gives port 0 strict, unmetered priority.
`timescale 1ns/1ps
module eth_drr_arbiter #(
  parameter int S_COUNT       = 4,
  parameter int KEEP_WIDTH    = 1,
  parameter int QUANTUM_WIDTH = 16,
  parameter int DEFICIT_WIDTH = 18
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [S_COUNT-1:0]               request,
  input  logic [S_COUNT*QUANTUM_WIDTH-1:0] quantum,
  input  logic                             beat_valid,
  input  logic [KEEP_WIDTH-1:0]            beat_keep,
  input  logic                             beat_last,
  output logic [S_COUNT-1:0]               grant,
  output logic                             grant_valid,
  output logic [$clog2(S_COUNT)-1:0]       grant_encoded,
  output logic [S_COUNT-1:0]               deficit_neg
);
  localparam int IW = $clog2(S_COUNT);
  localparam int DW = DEFICIT_WIDTH;
  localparam logic signed [DW:0] SAT_MAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] SAT_MIN = {2'b11, {(DW-1){1'b0}}};

  typedef enum logic {ST_SELECT, ST_ACTIVE} state_t;

  logic [QUANTUM_WIDTH-1:0] quant [S_COUNT];
  logic signed [DW-1:0]     deficit_q [S_COUNT];
  logic signed [DW-1:0]     deficit_d [S_COUNT];
  state_t                   state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d, ptr_inc;
  logic [IW-1:0]            enc_q, enc_d;
  logic                     fresh_q, fresh_d;
  logic [S_COUNT-1:0]       grant_q, grant_d;
  logic                     grant_valid_q, grant_valid_d;
  logic signed [DW:0]       beat_bytes;
  logic signed [DW-1:0]     eff, metered;
  logic [QUANTUM_WIDTH-1:0] cur_quant;
  logic                     strict_hold;

  function automatic logic signed [DW:0] sext(input logic signed [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] v);
    logic signed [DW-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[DW-1:0];
    else                  r = v[DW-1:0];
    return r;
  endfunction

  function automatic logic is_pos(input logic signed [DW-1:0] v);
    return !v[DW-1] && (|v);
  endfunction

  for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_port
    assign quant[gi]       = quantum[gi*QUANTUM_WIDTH +: QUANTUM_WIDTH];
    assign deficit_neg[gi] = deficit_q[gi][DW-1];
  end

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      beat_bytes = beat_bytes + $signed({{DW{1'b0}}, beat_keep[i]});
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    fresh_d       = fresh_q;
    enc_d         = enc_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    deficit_d     = deficit_q;
    strict_hold   = 1'b0;

    cur_quant = quant[ptr_q];
    ptr_inc   = (ptr_q == IW'(S_COUNT-1)) ? '0 : ptr_q + 1'b1;
    // The quantum is folded in only on the first visit of a round (fresh).
    eff = fresh_q ? sat(sext(deficit_q[ptr_q]) +
                        $signed({{(DW+1-QUANTUM_WIDTH){1'b0}}, cur_quant}))
                  : deficit_q[ptr_q];
    metered = sat(sext(deficit_q[enc_q]) - beat_bytes);
`ifdef ETH_DRR_ARBITER_STRICT_PRIO_EN
    strict_hold = (enc_q == '0);
`endif

    case (state_q)
      ST_SELECT: begin
        if (|request) begin
`ifdef ETH_DRR_ARBITER_STRICT_PRIO_EN
          if (request[0]) begin
            grant_d       = '0;
            grant_d[0]    = 1'b1;
            grant_valid_d = 1'b1;
            enc_d         = '0;
            state_d       = ST_ACTIVE;
          end else
`endif
          if (request[ptr_q] && (cur_quant != '0) && is_pos(eff)) begin
            deficit_d[ptr_q] = eff;
            grant_d          = '0;
            grant_d[ptr_q]   = 1'b1;
            grant_valid_d    = 1'b1;
            enc_d            = ptr_q;
            fresh_d          = 1'b0;
            state_d          = ST_ACTIVE;
          end else begin
            deficit_d[ptr_q] = (request[ptr_q] && (cur_quant != '0)) ? eff : '0;
            ptr_d            = ptr_inc;
            fresh_d          = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (beat_valid) begin
          if (!strict_hold)
            deficit_d[enc_q] = metered;
          if (beat_last) begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            enc_d         = '0;
            state_d       = ST_SELECT;
            // A strict-priority frame leaves the DRR round untouched.
            if (!strict_hold) begin
              if (request[ptr_q] && is_pos(metered)) begin
                fresh_d = 1'b0;
              end else begin
                ptr_d   = ptr_inc;
                fresh_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = ST_SELECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_SELECT;
      ptr_q         <= '0;
      fresh_q       <= 1'b1;
      enc_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      for (int i = 0; i < S_COUNT; i++)
        deficit_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      fresh_q       <= fresh_d;
      enc_q         <= enc_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      for (int i = 0; i < S_COUNT; i++)
        deficit_q[i] <= deficit_d[i];
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = grant_valid_q;
  assign grant_encoded = enc_q;

endmodule

// File: tb/tb_eth_drr_arbiter.sv
// Directed self-checking bench for eth_drr_arbiter (4 ports, 4-byte beats).
`timescale 1ns/1ps
module tb_eth_drr_arbiter;
  localparam int S_COUNT = 4;
  localparam int KW      = 4;
  localparam int QW      = 16;
  localparam int DW      = 18;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [S_COUNT-1:0] request = '0;
  logic [S_COUNT*QW-1:0] quantum = '0;
  logic              beat_valid = 1'b0;
  logic [KW-1:0]     beat_keep = '0;
  logic              beat_last = 1'b0;
  logic [S_COUNT-1:0] grant;
  logic              grant_valid;
  logic [1:0]        grant_encoded;
  logic [S_COUNT-1:0] deficit_neg;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  eth_drr_arbiter #(
    .S_COUNT(S_COUNT), .KEEP_WIDTH(KW), .QUANTUM_WIDTH(QW), .DEFICIT_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .quantum(quantum),
    .beat_valid(beat_valid), .beat_keep(beat_keep), .beat_last(beat_last),
    .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded),
    .deficit_neg(deficit_neg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_quanta(input int q0, input int q1, input int q2, input int q3);
    quantum = {QW'(q3), QW'(q2), QW'(q1), QW'(q0)};
  endtask

  task automatic do_reset();
    rst_n = 1'b0; request = '0; beat_valid = 1'b0; beat_keep = '0; beat_last = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic send_beats(input int bytes, input int maxb, input bit with_last);
    int rem;
    int n;
    rem = bytes;
    while (rem > 0) begin
      n = (rem > maxb) ? maxb : rem;
      beat_valid = 1'b1;
      beat_keep  = KW'((1 << n) - 1);
      beat_last  = with_last && (rem == n);
      tick();
      rem -= n;
    end
    beat_valid = 1'b0; beat_keep = '0; beat_last = 1'b0;
  endtask

  task automatic wait_grant(output int port);
    int cyc;
    cyc = 0;
    port = -1;
    while (grant_valid !== 1'b1 && cyc < 64) begin
      tick();
      cyc++;
    end
    vectors++;
    if (grant_valid !== 1'b1) begin
      $display("FAIL wait_grant: grant_valid=%b after %0d cycles, required 1", grant_valid, cyc);
      miscompares++;
    end else begin
      port = int'(grant_encoded);
      vectors++;
      if (grant !== (4'b0001 << grant_encoded)) begin
        $display("FAIL grant_consistency: grant=%b encoded=%0d", grant, grant_encoded);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset();
    set_quanta(64, 64, 64, 64);
    rst_n = 1'b0; request = 4'b1111;
    tick(); tick();
    vectors++;
    if (grant !== 4'b0000) begin
      $display("FAIL reset_grant: got %b, required 0000", grant); miscompares++;
    end
    vectors++;
    if (grant_valid !== 1'b0) begin
      $display("FAIL reset_grant_valid: got %b, required 0", grant_valid); miscompares++;
    end
    vectors++;
    if (grant_encoded !== 2'd0) begin
      $display("FAIL reset_grant_encoded: got %0d, required 0", grant_encoded); miscompares++;
    end
    vectors++;
    if (deficit_neg !== 4'b0000) begin
      $display("FAIL reset_deficit_neg: got %b, required 0000", deficit_neg); miscompares++;
    end
    $display("test_reset done");
  endtask

  task automatic test_single_port();
    set_quanta(64, 64, 64, 64);
    do_reset();
    tick(); tick(); tick();
    vectors++;
    if (grant_valid !== 1'b0) begin
      $display("FAIL idle_no_grant: grant_valid=%b, required 0", grant_valid); miscompares++;
    end
    request = 4'b0001;
    tick();
    vectors++;
    if (grant !== 4'b0001 || grant_encoded !== 2'd0) begin
      $display("FAIL first_grant: grant=%b enc=%0d, required 0001/0", grant, grant_encoded); miscompares++;
    end
    send_beats(2, 1, 1'b1);
    vectors++;
    if (grant_valid !== 1'b0) begin
      $display("FAIL last_drops_grant: grant_valid=%b, required 0", grant_valid); miscompares++;
    end
    tick();
    vectors++;
    if (grant !== 4'b0001) begin
      $display("FAIL regrant_leftover: grant=%b, required 0001", grant); miscompares++;
    end
    // Leftover credit is 62: 62 bytes reach exactly zero, one more goes negative.
    send_beats(62, 1, 1'b0);
    vectors++;
    if (deficit_neg !== 4'b0000) begin
      $display("FAIL deficit_zero: deficit_neg=%b, required 0000", deficit_neg); miscompares++;
    end
    send_beats(1, 1, 1'b1);
    vectors++;
    if (deficit_neg !== 4'b0001) begin
      $display("FAIL deficit_minus1: deficit_neg=%b, required 0001", deficit_neg); miscompares++;
    end
    tick(); tick(); tick();
    vectors++;
    if (grant_valid !== 1'b0) begin
      $display("FAIL scan_wait: grant_valid=%b, required 0", grant_valid); miscompares++;
    end
    tick();
    vectors++;
    if (grant !== 4'b0001 || deficit_neg !== 4'b0000) begin
      $display("FAIL next_round_grant: grant=%b deficit_neg=%b, required 0001/0000", grant, deficit_neg);
      miscompares++;
    end
    request = '0;
    send_beats(63, 4, 1'b1);
    $display("test_single_port done");
  endtask

  task automatic test_full_scan();
    set_quanta(64, 64, 64, 64);
    do_reset();
    request = 4'b1000;
    tick(); tick(); tick();
    vectors++;
    if (grant_valid !== 1'b0) begin
      $display("FAIL full_scan_early: grant_valid=%b, required 0", grant_valid); miscompares++;
    end
    tick();
    vectors++;
    if (grant !== 4'b1000 || grant_encoded !== 2'd3) begin
      $display("FAIL full_scan_grant: grant=%b enc=%0d, required 1000/3", grant, grant_encoded); miscompares++;
    end
    request = '0;
    send_beats(16, 4, 1'b1);
    $display("test_full_scan done");
  endtask

  task automatic test_quantum_weight();
    int exp_seq [5] = '{0, 0, 1, 2, 3};
    int port;
    set_quanta(128, 64, 64, 64);
    do_reset();
    request = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      wait_grant(port);
      if (port < 0) break;
      vectors++;
      if (port != exp_seq[i % 5]) begin
        $display("FAIL weight_order[%0d]: port %0d, required %0d", i, port, exp_seq[i % 5]); miscompares++;
      end
      send_beats(64, 4, 1'b1);
    end
    request = '0;
    $display("test_quantum_weight done");
  endtask

  task automatic test_zero_quantum();
    int exp_seq [3] = '{0, 1, 3};
    int port;
    set_quanta(64, 64, 0, 64);
    do_reset();
    request = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      wait_grant(port);
      if (port < 0) break;
      vectors++;
      if (port != exp_seq[i % 3]) begin
        $display("FAIL zero_quantum_order[%0d]: port %0d, required %0d", i, port, exp_seq[i % 3]); miscompares++;
      end
      send_beats(64, 4, 1'b1);
    end
    request = '0;
    $display("test_zero_quantum done");
  endtask

  task automatic test_ratio();
    int port;
    int b0;
    int b1;
    int diff;
    b0 = 0; b1 = 0;
    set_quanta(64, 64, 64, 64);
    do_reset();
    request = 4'b0011;
    for (int f = 0; f < 1000 && (b0 + b1) < 20000; f++) begin
      wait_grant(port);
      if (port < 0) break;
      if (port == 0) begin
        send_beats(100, 4, 1'b1); b0 += 100;
      end else begin
        vectors++;
        if (port != 1) begin
          $display("FAIL ratio_port: granted %0d, required 0 or 1", port); miscompares++;
        end
        send_beats(50, 4, 1'b1); b1 += 50;
      end
    end
    request = '0;
    diff = (b0 > b1) ? b0 - b1 : b1 - b0;
    vectors++;
    if (b1 == 0 || diff * 100 > b1 * 5) begin
      $display("FAIL byte_ratio: port0=%0d port1=%0d bytes, required ratio within 1+-0.05", b0, b1);
      miscompares++;
    end
    $display("test_ratio done: port0=%0d port1=%0d bytes", b0, b1);
  endtask

  task automatic test_reset_mid_frame();
    int port;
    set_quanta(64, 64, 64, 64);
    do_reset();
    request = 4'b0010;
    wait_grant(port);
    vectors++;
    if (port != 1) begin
      $display("FAIL mid_reset_setup: granted %0d, required 1", port); miscompares++;
    end
    send_beats(70, 4, 1'b0);
    vectors++;
    if (deficit_neg !== 4'b0010) begin
      $display("FAIL overdraw_neg: deficit_neg=%b, required 0010", deficit_neg); miscompares++;
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || deficit_neg !== 4'b0000) begin
      $display("FAIL mid_frame_reset: grant=%b valid=%b deficit_neg=%b, required 0000/0/0000",
               grant, grant_valid, deficit_neg);
      miscompares++;
    end
    rst_n = 1'b1;
    request = 4'b0011;
    tick();
    vectors++;
    if (grant !== 4'b0001) begin
      $display("FAIL post_reset_first: grant=%b, required 0001", grant); miscompares++;
    end
    request = '0;
    send_beats(16, 4, 1'b1);
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_ignored_inputs();
    set_quanta(64, 64, 64, 64);
    do_reset();
    send_beats(80, 4, 1'b1);
    vectors++;
    if (grant_valid !== 1'b0 || deficit_neg !== 4'b0000) begin
      $display("FAIL idle_beats: grant_valid=%b deficit_neg=%b, required 0/0000", grant_valid, deficit_neg);
      miscompares++;
    end
    request = 4'b0001;
    tick();
    vectors++;
    if (grant !== 4'b0001) begin
      $display("FAIL ignored_grant: grant=%b, required 0001", grant); miscompares++;
    end
    request = '0;
    send_beats(8, 4, 1'b0);
    vectors++;
    if (grant_valid !== 1'b1) begin
      $display("FAIL request_drop_holds: grant_valid=%b, required 1", grant_valid); miscompares++;
    end
    send_beats(4, 4, 1'b1);
    vectors++;
    if (grant_valid !== 1'b0) begin
      $display("FAIL request_drop_end: grant_valid=%b, required 0", grant_valid); miscompares++;
    end
    $display("test_ignored_inputs done");
  endtask

`ifdef ETH_DRR_ARBITER_STRICT_PRIO_EN
  task automatic test_strict_prio();
    int port;
    set_quanta(64, 64, 64, 64);
    do_reset();
    request = 4'b0010;
    wait_grant(port);
    send_beats(20, 4, 1'b0);
    request = 4'b0011;
    send_beats(4, 4, 1'b1);
    vectors++;
    if (grant_valid !== 1'b0) begin
      $display("FAIL strict_last: grant_valid=%b, required 0", grant_valid); miscompares++;
    end
    tick();
    vectors++;
    if (grant !== 4'b0001) begin
      $display("FAIL strict_grant: grant=%b, required 0001", grant); miscompares++;
    end
    request = 4'b0010;
    send_beats(70, 4, 1'b1);
    vectors++;
    if (deficit_neg !== 4'b0000) begin
      $display("FAIL strict_unmetered: deficit_neg=%b, required 0000", deficit_neg); miscompares++;
    end
    tick();
    vectors++;
    if (grant !== 4'b0010) begin
      $display("FAIL strict_ptr_kept: grant=%b, required 0010", grant); miscompares++;
    end
    request = '0;
    send_beats(8, 4, 1'b1);
    $display("test_strict_prio done");
  endtask
`endif

  initial begin
    test_reset();
    test_single_port();
    test_full_scan();
    test_quantum_weight();
    test_zero_quantum();
    test_ratio();
    test_reset_mid_frame();
    test_ignored_inputs();
`ifdef ETH_DRR_ARBITER_STRICT_PRIO_EN
    test_strict_prio();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
